// File: rtl/dm_stage.sv
// dm_stage: memory-access stage of a 5-stage MIPS pipeline.
// Holds the data memory, performs word/half/byte stores and sign/zero
// extended loads, flags misaligned or out-of-range accesses, and produces
// the write-back triple for MEM/WB. Write-back outputs are combinational.
// Optional build macro DM_TRACE_EN: prints a trace line for every performed
// store (simulation only, no logic change).
module dm_stage #(
   parameter int DEPTH = 3072,
   parameter int AW    = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pcMEM,
   input  logic        MemWriteMEM,
   input  logic [2:0]  MemOpMEM,
   input  logic [31:0] AddrMEM,
   input  logic [31:0] WDataMEM,
   input  logic        RegWriteInMEM,
   input  logic [4:0]  RegAddrInMEM,
   input  logic [31:0] AluResultMEM,
   output logic        RegWriteMEM,
   output logic [4:0]  RegAddrMEM,
   output logic [31:0] RegDataMEM,
   output logic        MemExcMEM
);

   localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

   logic [31:0] mem [0:DEPTH-1];

   logic          is_word;
   logic          is_half;
   logic          is_byte;
   logic          is_signed;
   logic          access;
   logic          load;
   logic          store;
   logic          misaligned;
   logic          out_of_range;
   logic          fault;
   logic [AW-1:0] word_idx;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shifted;
   logic [31:0]   ld_data;
   logic [31:0]   wr_mask;
   logic [31:0]   wr_lane;
   logic [31:0]   wr_word;

   // Sign- or zero-extend a selected byte to 32 bits.
   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
      logic signed [7:0]  bs;
      logic signed [31:0] wide;
      bs   = b;
      wide = bs;
      return sgn ? wide : {24'b0, b};
   endfunction

   // Sign- or zero-extend a selected halfword to 32 bits.
   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
      logic signed [15:0] hs;
      logic signed [31:0] wide;
      hs   = h;
      wide = hs;
      return sgn ? wide : {16'b0, h};
   endfunction

   // Decode the access kind and detect faults.
   always_comb begin
      is_word   = 1'b0;
      is_half   = 1'b0;
      is_byte   = 1'b0;
      is_signed = 1'b0;
      case (MemOpMEM)
         3'b001:  is_word = 1'b1;
         3'b010:  begin is_half = 1'b1; is_signed = 1'b1; end
         3'b011:  is_half = 1'b1;
         3'b100:  begin is_byte = 1'b1; is_signed = 1'b1; end
         3'b101:  is_byte = 1'b1;
         default: ;
      endcase
      access       = is_word | is_half | is_byte;
      load         = access & ~MemWriteMEM;
      store        = access & MemWriteMEM;
      misaligned   = (is_word & (AddrMEM[1:0] != 2'b00)) | (is_half & AddrMEM[0]);
      out_of_range = (AddrMEM >= BYTE_LIMIT);
      fault        = access & (misaligned | out_of_range);
   end

   // Read the addressed word and extract the load field; build the merged store word.
   always_comb begin
      word_idx   = AddrMEM[AW+1:2];
      rd_word    = mem[word_idx];
      rd_shifted = rd_word >> {AddrMEM[1:0], 3'b000};
      if (is_word)
         ld_data = rd_word;
      else if (is_half)
         ld_data = ext_half(rd_shifted[15:0], is_signed);
      else
         ld_data = ext_byte(rd_shifted[7:0], is_signed);

      wr_mask = 32'h0;
      wr_lane = 32'h0;
      if (is_word) begin
         wr_mask = 32'hFFFF_FFFF;
         wr_lane = WDataMEM;
      end else if (is_half) begin
         wr_mask = AddrMEM[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
         wr_lane = {2{WDataMEM[15:0]}};
      end else if (is_byte) begin
         wr_mask = 32'h0000_00FF << {AddrMEM[1:0], 3'b000};
         wr_lane = {4{WDataMEM[7:0]}};
      end
      wr_word = (rd_word & ~wr_mask) | (wr_lane & wr_mask);
   end

   // Write-back mux; everything is forced to zero while reset is held.
   always_comb begin
      RegWriteMEM = 1'b0;
      RegAddrMEM  = 5'd0;
      RegDataMEM  = 32'h0;
      MemExcMEM   = 1'b0;
      if (!reset) begin
         RegWriteMEM = RegWriteInMEM & ~(load & fault);
         RegAddrMEM  = RegAddrInMEM;
         RegDataMEM  = (load & ~fault) ? ld_data : AluResultMEM;
         MemExcMEM   = fault;
      end
   end

   // Memory array: reset clears every word and discards any concurrent store.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      end else if (store && !fault) begin
         mem[word_idx] <= wr_word;
      end
   end

`ifdef DM_TRACE_EN
   // Trace every performed store with the resulting full word.
   always_ff @(posedge clk) begin
      if (!reset && store && !fault)
         $display("@%08h: *%08h <= %08h", pcMEM, {AddrMEM[31:2], 2'b00}, wr_word);
   end
`else
   logic unused_pc;
   assign unused_pc = ^pcMEM;
`endif

endmodule

// File: tb/tb_dm_stage.sv
// tb_dm_stage: directed and randomized bench for dm_stage with a byte-array
// reference model of the data memory.
module tb_dm_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pcMEM;
   logic        MemWriteMEM;
   logic [2:0]  MemOpMEM;
   logic [31:0] AddrMEM;
   logic [31:0] WDataMEM;
   logic        RegWriteInMEM;
   logic [4:0]  RegAddrInMEM;
   logic [31:0] AluResultMEM;
   logic        RegWriteMEM;
   logic [4:0]  RegAddrMEM;
   logic [31:0] RegDataMEM;
   logic        MemExcMEM;

   dm_stage dut (
      .clk(clk),
      .reset(reset),
      .pcMEM(pcMEM),
      .MemWriteMEM(MemWriteMEM),
      .MemOpMEM(MemOpMEM),
      .AddrMEM(AddrMEM),
      .WDataMEM(WDataMEM),
      .RegWriteInMEM(RegWriteInMEM),
      .RegAddrInMEM(RegAddrInMEM),
      .AluResultMEM(AluResultMEM),
      .RegWriteMEM(RegWriteMEM),
      .RegAddrMEM(RegAddrMEM),
      .RegDataMEM(RegDataMEM),
      .MemExcMEM(MemExcMEM)
   );

   always #5 clk = ~clk;

   localparam int          LIMIT   = 3072 * 4;
   localparam logic [31:0] LIMIT_B = 32'd12288;

   logic [7:0] mb [0:LIMIT-1];
   int checks = 0;
   int errors = 0;

   logic [31:0] s_data;
   logic [4:0]  s_addr;
   logic        s_rw;
   logic        s_exc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic int op_size(input logic [2:0] op);
      case (op)
         3'd1:       return 4;
         3'd2, 3'd3: return 2;
         3'd4, 3'd5: return 1;
         default:    return 0;
      endcase
   endfunction

   function automatic bit model_fault(input logic [2:0] op, input logic [31:0] addr);
      int sz;
      sz = op_size(op);
      if (sz == 0) return 1'b0;
      return ((addr % 32'(sz)) != 0) || (addr >= LIMIT_B);
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
      int     sz;
      longint v;
      sz = op_size(op);
      v  = 0;
      for (int i = 0; i < sz; i++) v += longint'(mb[addr + 32'(i)]) << (8 * i);
      if ((op == 3'd2 || op == 3'd4) && v >= (longint'(1) << (8 * sz - 1)))
         v -= longint'(1) << (8 * sz);
      return v[31:0];
   endfunction

   task automatic step(input string tag, input logic rst, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd, input logic rwin,
                       input logic [4:0] ra, input logic [31:0] alu, input logic [31:0] pc);
      int          sz;
      bit          ld, st, f;
      logic [31:0] e_data;
      logic [31:0] t;
      logic [4:0]  e_addr;
      logic        e_rw, e_exc;
      reset = rst; MemWriteMEM = we; MemOpMEM = op; AddrMEM = addr; WDataMEM = wd;
      RegWriteInMEM = rwin; RegAddrInMEM = ra; AluResultMEM = alu; pcMEM = pc;
      sz = op_size(op);
      ld = (sz != 0) && !we;
      st = (sz != 0) && we;
      f  = model_fault(op, addr);
      if (rst) begin
         e_rw = 1'b0; e_addr = 5'd0; e_data = 32'h0; e_exc = 1'b0;
      end else begin
         e_exc  = f;
         e_rw   = rwin && !(ld && f);
         e_addr = ra;
         e_data = (ld && !f) ? model_load(op, addr) : alu;
      end
      @(negedge clk);
      chk({tag, ".data"}, RegDataMEM, e_data);
      chk({tag, ".rw"}, 32'(RegWriteMEM), 32'(e_rw));
      chk({tag, ".ra"}, 32'(RegAddrMEM), 32'(e_addr));
      chk({tag, ".exc"}, 32'(MemExcMEM), 32'(e_exc));
      s_data = RegDataMEM; s_addr = RegAddrMEM; s_rw = RegWriteMEM; s_exc = MemExcMEM;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < LIMIT; i++) mb[i] = 8'h0;
      end else if (st && !f) begin
         for (int i = 0; i < sz; i++) begin
            t = wd >> (8 * i);
            mb[addr + 32'(i)] = t[7:0];
         end
      end
      #1;
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] addr;
      int          sel;
      reset = 1'b1; MemWriteMEM = 1'b0; MemOpMEM = 3'd0; AddrMEM = 32'h0; WDataMEM = 32'h0;
      RegWriteInMEM = 1'b0; RegAddrInMEM = 5'd0; AluResultMEM = 32'h0; pcMEM = 32'h0;
      @(posedge clk);
      #1;

      // reset, then load from cleared memory
      step("rst", 1, 0, 3'd1, 32'h10, 32'h0, 1, 5'd3, 32'h55, 32'h0);
      step("lw10", 0, 0, 3'd1, 32'h10, 32'h0, 1, 5'd3, 32'h55, 32'h2FFC);
      chk("lw10.zero", s_data, 32'h0);
      chk("lw10.rw", 32'(s_rw), 32'd1);

      // word store then narrow loads
      step("sw20", 0, 1, 3'd1, 32'h20, 32'h12345678, 0, 5'd0, 32'h20, 32'h3000);
      step("lb21", 0, 0, 3'd4, 32'h21, 32'h0, 1, 5'd4, 32'h0, 32'h3004);
      chk("lb21.val", s_data, 32'h00000056);
      step("lbu23", 0, 0, 3'd5, 32'h23, 32'h0, 1, 5'd5, 32'h0, 32'h3008);
      chk("lbu23.val", s_data, 32'h00000012);
      step("lh22", 0, 0, 3'd2, 32'h22, 32'h0, 1, 5'd6, 32'h0, 32'h300C);
      chk("lh22.val", s_data, 32'h00001234);

      // halfword store into an existing word
      step("sw40", 0, 1, 3'd1, 32'h40, 32'h0000F0F0, 0, 5'd0, 32'h40, 32'h3010);
      step("sh42", 0, 1, 3'd2, 32'h42, 32'h0000FF80, 0, 5'd0, 32'h42, 32'h3014);
      step("lw40", 0, 0, 3'd1, 32'h40, 32'h0, 1, 5'd7, 32'h0, 32'h3018);
      chk("lw40.val", s_data, 32'hFF80F0F0);
      step("lh42", 0, 0, 3'd2, 32'h42, 32'h0, 1, 5'd7, 32'h0, 32'h301C);
      chk("lh42.val", s_data, 32'hFFFFFF80);
      step("lhu42", 0, 0, 3'd3, 32'h42, 32'h0, 1, 5'd7, 32'h0, 32'h3020);
      chk("lhu42.val", s_data, 32'h0000FF80);

      // misaligned accesses
      step("sw45", 0, 1, 3'd1, 32'h45, 32'hCAFEBABE, 0, 5'd0, 32'h45, 32'h3024);
      chk("sw45.exc", 32'(s_exc), 32'd1);
      step("lw44", 0, 0, 3'd1, 32'h44, 32'h0, 1, 5'd8, 32'h0, 32'h3028);
      chk("lw44.val", s_data, 32'h0);
      step("lw46", 0, 0, 3'd1, 32'h46, 32'h0, 1, 5'd8, 32'h77, 32'h302C);
      chk("lw46.rw", 32'(s_rw), 32'd0);
      chk("lw46.exc", 32'(s_exc), 32'd1);
      step("lh43", 0, 0, 3'd2, 32'h43, 32'h0, 1, 5'd8, 32'h66, 32'h3030);
      step("lb43", 0, 0, 3'd4, 32'h43, 32'h0, 1, 5'd8, 32'h66, 32'h3030);

      // range boundary and non-memory ops
      step("lw3000", 0, 0, 3'd1, 32'h3000, 32'h0, 1, 5'd2, 32'h11, 32'h3034);
      chk("lw3000.exc", 32'(s_exc), 32'd1);
      chk("lw3000.rw", 32'(s_rw), 32'd0);
      step("sw2FFC", 0, 1, 3'd1, 32'h2FFC, 32'h0BADF00D, 0, 5'd0, 32'h0, 32'h3038);
      step("lw2FFC", 0, 0, 3'd1, 32'h2FFC, 32'h0, 1, 5'd2, 32'h0, 32'h303C);
      chk("lw2FFC.val", s_data, 32'h0BADF00D);
      step("lbuHuge", 0, 0, 3'd5, 32'hFFFFFFFF, 32'h0, 1, 5'd2, 32'h22, 32'h3040);
      step("nop", 0, 0, 3'd0, 32'h47, 32'h0, 1, 5'd9, 32'hDEADBEEF, 32'h3044);
      chk("nop.data", s_data, 32'hDEADBEEF);
      chk("nop.ra", 32'(s_addr), 32'd9);
      chk("nop.exc", 32'(s_exc), 32'd0);
      step("op7", 0, 1, 3'd7, 32'h20, 32'hFFFFFFFF, 1, 5'd10, 32'h1234, 32'h3048);
      step("lw20", 0, 0, 3'd1, 32'h20, 32'h0, 1, 5'd11, 32'h0, 32'h304C);
      chk("lw20.val", s_data, 32'h12345678);

      // store discarded by a concurrent reset
      step("sw80", 0, 1, 3'd1, 32'h80, 32'h11111111, 0, 5'd0, 32'h0, 32'h3050);
      step("swrst", 1, 1, 3'd1, 32'h80, 32'hAAAAAAAA, 1, 5'd12, 32'h99, 32'h3054);
      step("lw80", 0, 0, 3'd1, 32'h80, 32'h0, 1, 5'd12, 32'h0, 32'h3058);
      chk("lw80.val", s_data, 32'h0);

      // randomized traffic against the byte model
      for (int n = 0; n < 600; n++) begin
         op  = 3'($urandom_range(0, 7));
         sel = int'($urandom_range(0, 9));
         if (sel < 7)       addr = 32'($urandom_range(0, 255));
         else if (sel == 7) addr = 32'h2FF0 + 32'($urandom_range(0, 31));
         else               addr = $urandom;
         step("rnd", 1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)), op, addr,
              $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm_stage.md
Name: dm_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Holds the data memory array and performs word, halfword and byte stores.
- Performs loads with sign or zero extension, and detects misaligned and out-of-range accesses.
- Produces the write-back triple (write enable, register address, register data) consumed by MEM/WB.

Parameters:
- DEPTH, 3072, number of 32-bit words in the data memory (byte range 0 .. DEPTH*4-1)
- AW, 12, word-index width; must satisfy 2^AW >= DEPTH

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- pcMEM  input  32  PC of the instruction in MEM (used for trace output only)
- MemWriteMEM  input  1  1 = store instruction
- MemOpMEM  input  3  access kind: 000 none, 001 word, 010 half signed, 011 half unsigned, 100 byte signed, 101 byte unsigned; 110/111 treated as none
- AddrMEM  input  32  byte address (ALU result)
- WDataMEM  input  32  store data (rt value, already forwarded)
- RegWriteInMEM  input  1  instruction writes a GPR
- RegAddrInMEM  input  5  destination GPR
- AluResultMEM  input  32  non-load write-back value
- RegWriteMEM  output  1  write enable to MEM/WB
- RegAddrMEM  output  5  destination to MEM/WB
- RegDataMEM  output  32  write-back data to MEM/WB
- MemExcMEM  output  1  access fault flag (misaligned or out of range)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, port names clk and reset.
- Reset: on a posedge with reset=1, every memory word is cleared to 0.
- Outputs during reset: while reset=1, RegWriteMEM=0, RegAddrMEM=0, RegDataMEM=0 and MemExcMEM=0, regardless of inputs.
- Access decode:
  - access = MemOpMEM in {001..101}
  - load = access & !MemWriteMEM
  - store = access & MemWriteMEM
  - A store with signed/unsigned half or byte uses the same width: 010/011 store a half, 100/101 store a byte.
- Fault detection, combinational:
  - misaligned = (word & AddrMEM[1:0]!=0) | (half & AddrMEM[0]!=0)
  - out of range = AddrMEM >= DEPTH*4 (full 32-bit compare)
  - MemExcMEM = access & (misaligned | out of range)
- Store timing: performed on the posedge when store=1, MemExcMEM=0 and reset=0. Only the addressed bytes change:
  - word writes all 4 bytes
  - half writes bytes {AddrMEM[1],0} and {AddrMEM[1],1} from WDataMEM[15:0]
  - byte writes byte AddrMEM[1:0] from WDataMEM[7:0]
  - Byte lanes are little-endian: byte 0 = bits [7:0].
- Faulting store: the memory is left unchanged.
- Load read: combinational from the array at index AddrMEM[AW+1:2].
  - Half/byte lane is selected by AddrMEM[1:0].
  - Signed ops replicate the top bit of the selected field into bits 31 and above; unsigned ops zero-fill.
- Store-to-load ordering: a store in cycle N is visible to a load in cycle N+1. A load never sees a write that is in progress in the same cycle.
- Write-back mux:
  - RegAddrMEM = RegAddrInMEM
  - RegDataMEM = extended load data when load & !MemExcMEM, else AluResultMEM
  - RegWriteMEM = RegWriteInMEM & !(load & MemExcMEM)
  - A faulting load never writes a GPR.
- RegAddrInMEM=0: passed through unchanged; $0 suppression is the register file's job.
- Latency: write-back outputs are combinational (0 cycles) and are registered by MEM/WB. The memory effect of a store lands at the end of its MEM cycle.
- Reset mid-store: reset takes priority; the whole array is cleared and the store is discarded.

Optional Feature:
- DM_TRACE_EN defined: on every performed store, a simulation-only $display prints "@<pcMEM hex8>: *<word-aligned byte address hex8> <= <resulting full word hex8>". Faulting stores and reset do not print. No synthesizable logic changes.
- DM_TRACE_EN undefined: no display statements are compiled; behaviour is otherwise identical.

Test Plan:
- reset=1 for 1 cycle, then lw @0x10 → RegDataMEM=0x00000000, MemExcMEM=0, RegWriteMEM follows RegWriteInMEM.
- sw 0x12345678 @0x20; next cycle lb @0x21 → 0x00000056; lbu @0x23 → 0x00000012; lh @0x22 → 0x00001234.
- sw 0x0000F0F0 @0x40, then sh 0xFF80 @0x42 → word 0xFF80F0F0; lh @0x42 → 0xFFFFFF80; lhu @0x42 → 0x0000FF80.
- sw @0x45 → MemExcMEM=1, word at 0x44 unchanged. lw @0x46 with RegWriteInMEM=1 → RegWriteMEM=0, MemExcMEM=1.
- lw @0x3000 (DEPTH=3072) → MemExcMEM=1, RegWriteMEM=0. Non-memory op (MemOp=000) with AluResultMEM=0xDEADBEEF, RegAddrInMEM=9 → RegDataMEM=0xDEADBEEF, RegAddrMEM=9, MemExcMEM=0.
- sw 0xAAAAAAAA @0x80 with reset asserted in the same cycle → after the edge, lw @0x80 = 0x00000000 and the outputs were 0 during reset. With DM_TRACE_EN defined, the earlier valid sw at pc 0x3000 prints "@00003000: *00000020 <= 12345678".
